// File: rtl/clk_div_controller.sv
// Run/stop and rate controller for a programmable clock divider.
// Produces a 50%-duty divided clock and tick; ratio updates land only on falling boundaries.
module clk_div_controller #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             out_clk,
  output logic             tick,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             stop_pend_q, stop_pend_d;
  logic             out_clk_d, tick_d, cfg_ready_d, cfg_err_d, busy_d;

  logic             xfer;
  logic             xfer_nz;
  logic             half_done;
  logic             fall_edge;
  logic             stopping;

  assign xfer      = cfg_valid & cfg_ready;
  assign xfer_nz   = xfer & (cfg_div != '0);
  assign half_done = (cnt_q == (div_q - WIDTH'(1)));
  assign fall_edge = (state_q == RUN) & half_done & out_clk;
  assign stopping  = fall_edge & stop_pend_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    stop_pend_d  = stop_pend_q;
    out_clk_d    = out_clk;
    tick_d       = 1'b0;
    cfg_ready_d  = cfg_ready;
    cfg_err_d    = xfer & (cfg_div == '0);

    case (state_q)
      IDLE: begin
        cnt_d        = '0;
        out_clk_d    = 1'b0;
        pend_valid_d = 1'b0;
        stop_pend_d  = 1'b0;
        cfg_ready_d  = 1'b1;
        if (xfer_nz) begin
          div_d = cfg_div;
        end
        if (start && !stop) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (half_done) begin
          cnt_d     = '0;
          out_clk_d = ~out_clk;
          tick_d    = ~out_clk;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end

        if (stop) begin
          stop_pend_d = 1'b1;
        end

        // Falling boundary: commit pending ratio, then honour a pending stop
        if (fall_edge) begin
          if (pend_valid_q) begin
            div_d        = pend_div_q;
            pend_valid_d = 1'b0;
            cfg_ready_d  = 1'b1;
          end
          if (stop_pend_q) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end
        end

        // A ratio arriving as we drop to IDLE needs no parking slot
        if (xfer_nz) begin
          if (stopping) begin
            div_d = cfg_div;
          end else begin
            pend_div_d   = cfg_div;
            pend_valid_d = 1'b1;
            cfg_ready_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= WIDTH'(DEFAULT_DIV);
      cnt_q        <= '0;
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      out_clk      <= 1'b0;
      tick         <= 1'b0;
      cfg_ready    <= 1'b1;
      cfg_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      stop_pend_q  <= stop_pend_d;
      out_clk      <= out_clk_d;
      tick         <= tick_d;
      cfg_ready    <= cfg_ready_d;
      cfg_err      <= cfg_err_d;
      busy         <= busy_d;
    end
  end

endmodule
